// File: rtl/counter_pkg.sv
// Shared definitions for the lab counters (up and down variants).
package counter_pkg;

    // Default count width, shared with the up counter.
    localparam int unsigned CNT_WIDTH = 12;

    // Counter lifecycle states.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StExpired = 2'd2
    } cnt_state_e;

endpackage : counter_pkg

// File: rtl/down_counter.sv
// Loadable countdown counter with terminal-count done pulse and optional auto-reload.
// Priority per edge: rst > load > en. The count never decrements from zero.
module down_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = CNT_WIDTH,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             done,
    output logic             busy,
    output logic             expired
);

    cnt_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    logic             at_one;
    logic             step;
    logic             terminal;

    // Decrement only happens in RUN with a strobe that is not overridden by load.
    always_comb begin
        at_one   = (q_q == WIDTH'(1));
        step     = (state_q == StRun) && en && !load;
        terminal = step && at_one;
    end

    // Next-state, next-count and done pulse.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load) begin
            q_d      = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? StRun : StIdle;
        end else if (terminal) begin
            done_d = 1'b1;
            if (AUTO_RELOAD) begin
                q_d     = reload_q;
                state_d = StRun;
            end else begin
                q_d     = '0;
                state_d = StExpired;
            end
        end else if (step) begin
            if (q_q != '0) begin
                q_d = q_q - WIDTH'(1);
            end else begin
                // Unreachable in normal operation; park safely instead of wrapping.
                state_d = StIdle;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            q_q      <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Registered / state-decoded outputs; zero is a pure compare on the count.
    always_comb begin
        q       = q_q;
        zero    = (q_q == '0);
        done    = done_q;
        busy    = (state_q == StRun);
        expired = (state_q == StExpired);
    end

endmodule : down_counter

// File: tb/tb_down_counter.sv
// Self-checking bench: two instances (stop-at-zero and auto-reload) share stimulus and are
// compared against an integer reference model of the counting rules.
module tb_down_counter;

    localparam int W = 12;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;

    logic [W-1:0] q0, q1;
    logic         zero0, zero1, done0, done1, busy0, busy1, exp0, exp1;

    int n_checks;
    int n_fail;

    // Reference model state, index 0 = stop-at-zero, 1 = auto-reload.
    int m_q    [2];
    int m_rl   [2];
    bit m_run  [2];
    bit m_exp  [2];
    bit m_done [2];

    down_counter #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .q        (q0),
        .zero     (zero0),
        .done     (done0),
        .busy     (busy0),
        .expired  (exp0)
    );

    down_counter #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .q        (q1),
        .zero     (zero1),
        .done     (done1),
        .busy     (busy1),
        .expired  (exp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_q[k] = 0; m_rl[k] = 0; m_run[k] = 0; m_exp[k] = 0; m_done[k] = 0;
        end
    endfunction

    // One rising edge of the counting rules, from the specification's point of view.
    function automatic void model_edge();
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 0;
            if (load) begin
                m_q[k]   = int'(load_val);
                m_rl[k]  = int'(load_val);
                m_run[k] = (load_val != 0);
                m_exp[k] = 0;
            end else if (m_run[k] && en) begin
                if (m_q[k] == 1) begin
                    m_done[k] = 1;
                    if (k == 1) begin
                        m_q[k] = m_rl[k];
                    end else begin
                        m_q[k] = 0; m_run[k] = 0; m_exp[k] = 1;
                    end
                end else begin
                    m_q[k] = m_q[k] - 1;
                end
            end
        end
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".q0"},    32'(q0),    32'(m_q[0]));
        chk({tag, ".zero0"}, 32'(zero0), 32'(m_q[0] == 0));
        chk({tag, ".done0"}, 32'(done0), 32'(m_done[0]));
        chk({tag, ".busy0"}, 32'(busy0), 32'(m_run[0]));
        chk({tag, ".exp0"},  32'(exp0),  32'(m_exp[0]));
        chk({tag, ".q1"},    32'(q1),    32'(m_q[1]));
        chk({tag, ".zero1"}, 32'(zero1), 32'(m_q[1] == 0));
        chk({tag, ".done1"}, 32'(done1), 32'(m_done[1]));
        chk({tag, ".busy1"}, 32'(busy1), 32'(m_run[1]));
        chk({tag, ".exp1"},  32'(exp1),  32'(m_exp[1]));
    endtask

    // Apply current inputs at the next rising edge, check at the following falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic drive(input logic l, input int v, input logic e);
        load     = l;
        load_val = W'(v);
        en       = e;
    endtask

    // Asynchronous reset pulse applied between edges.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_model(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst = 1'b1;
        drive(1'b0, 0, 1'b0);

        // Reset state.
        @(negedge clk);
        check_model("reset");
        chk("reset.q_lit", 32'(q0), 32'd0);
        chk("reset.zero_lit", 32'(zero0), 32'd1);
        rst = 1'b0;

        // Load 3, three single-cycle strobes.
        drive(1'b1, 3, 1'b0); tick("ld3");
        chk("ld3.q_lit", 32'(q0), 32'd3);
        chk("ld3.busy_lit", 32'(busy0), 32'd1);
        drive(1'b0, 0, 1'b1); tick("s1");
        chk("s1.q_lit", 32'(q0), 32'd2);
        drive(1'b0, 0, 1'b0); tick("gap1");
        drive(1'b0, 0, 1'b1); tick("s2");
        chk("s2.q_lit", 32'(q0), 32'd1);
        chk("s2.done_lit", 32'(done0), 32'd0);
        drive(1'b0, 0, 1'b0); tick("gap2");
        drive(1'b0, 0, 1'b1); tick("s3");
        chk("s3.q_lit", 32'(q0), 32'd0);
        chk("s3.done_lit", 32'(done0), 32'd1);
        chk("s3.exp_lit", 32'(exp0), 32'd1);
        chk("s3.busy_lit", 32'(busy0), 32'd0);

        // Expired: en held, no wrap.
        for (int i = 0; i < 4; i++) begin
            tick("exp_hold");
            chk("exp_hold.q_lit", 32'(q0), 32'd0);
            chk("exp_hold.done_lit", 32'(done0), 32'd0);
        end

        // Auto-reload with start value 2, en held 6 cycles.
        drive(1'b1, 2, 1'b0); tick("ar_ld");
        drive(1'b0, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick("ar_run");
            chk("ar_run.q_lit", 32'(q1), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("ar_run.done_lit", 32'(done1), (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("ar_run.busy_lit", 32'(busy1), 32'd1);
        end

        // Load overrides a simultaneous strobe.
        drive(1'b1, 5, 1'b0); tick("ld5");
        drive(1'b0, 0, 1'b1); tick("ld5.s");
        tick("ld5.s");
        chk("ld5.q_lit", 32'(q0), 32'd3);
        drive(1'b1, 9, 1'b1); tick("ld9en");
        chk("ld9en.q_lit", 32'(q0), 32'd9);
        chk("ld9en.done_lit", 32'(done0), 32'd0);

        // Asynchronous reset mid-count.
        drive(1'b1, 10, 1'b0); tick("ld10");
        drive(1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) tick("to6");
        chk("to6.q_lit", 32'(q0), 32'd6);
        async_reset("arst");
        chk("arst.q_lit", 32'(q0), 32'd0);
        chk("arst.busy_lit", 32'(busy0), 32'd0);
        for (int i = 0; i < 3; i++) tick("post_rst");

        // Reset landing right after a terminal count clears done immediately.
        drive(1'b1, 1, 1'b0); tick("ld1a");
        drive(1'b0, 0, 1'b1); tick("term_a");
        chk("term_a.done_lit", 32'(done0), 32'd1);
        async_reset("arst_done");
        chk("arst_done.done_lit", 32'(done0), 32'd0);

        // Load of zero stays idle; then load 1 and one strobe.
        drive(1'b1, 0, 1'b0); tick("ld0");
        chk("ld0.zero_lit", 32'(zero0), 32'd1);
        chk("ld0.busy_lit", 32'(busy0), 32'd0);
        drive(1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) tick("idle_en");
        drive(1'b1, 1, 1'b0); tick("ld1");
        drive(1'b0, 0, 1'b1); tick("term1");
        chk("term1.q_lit", 32'(q0), 32'd0);
        chk("term1.done_lit", 32'(done0), 32'd1);
        drive(1'b0, 0, 1'b0); tick("term1.after");
        chk("term1.after.done_lit", 32'(done0), 32'd0);

        // Full-scale load: 4095 enabled cycles to terminal.
        drive(1'b1, 4095, 1'b0); tick("ld4095");
        drive(1'b0, 0, 1'b1);
        for (int i = 0; i < 4094; i++) tick("big");
        chk("big.pre_q_lit", 32'(q0), 32'd1);
        tick("big.term");
        chk("big.term.done_lit", 32'(done0), 32'd1);
        chk("big.term.q1_lit", 32'(q1), 32'd4095);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int v;
            v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4095))
                                            : int'($urandom_range(0, 5));
            drive(($urandom_range(0, 7) == 0), v, ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_down_counter
